// File: rtl/ballot_sequencer.sv
// Transmit-side sequencer for the voting-machine pins: queues vote requests and replays
// each one with fixed setup/pulse/hold timing, plus clear (mode 10) and close (mode 01).
module ballot_sequencer #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned CLEAR_CYC  = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vote_valid,
    input  logic [1:0] vote_cand,
    output logic       vote_ready,
    input  logic       close_req,
    input  logic       clear_req,
    output logic [3:0] voter,
    output logic       confirm,
    output logic [1:0] mode,
    output logic       busy,
    output logic [7:0] sent_count
);

    localparam int unsigned MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_HC = (HOLD_CYC > CLEAR_CYC) ? HOLD_CYC : CLEAR_CYC;
    localparam int unsigned MAX_C  = (MAX_SP > MAX_HC) ? MAX_SP : MAX_HC;
    localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned NW     = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_CLEAR, S_CLOSED
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      mem_q [FIFO_DEPTH];
    logic [1:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0]   count_q, count_d;
    logic            close_pend_q, close_pend_d;
    logic [3:0]      voter_q, voter_d;
    logic            confirm_q, confirm_d;
    logic [1:0]      mode_q, mode_d;
    logic            busy_q, busy_d;
    logic [7:0]      sent_q, sent_d;
    logic            push, pop, go_clear;

    assign vote_ready = (count_q != NW'(FIFO_DEPTH)) && !clear_req &&
                        (state_q != S_CLEAR) && (state_q != S_CLOSED);
    assign push       = vote_valid && vote_ready;

    assign voter      = voter_q;
    assign confirm    = confirm_q;
    assign mode       = mode_q;
    assign busy       = busy_q;
    assign sent_count = sent_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_d        = mem_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        count_d      = count_q;
        close_pend_d = close_pend_q || close_req;
        voter_d      = voter_q;
        confirm_d    = confirm_q;
        mode_d       = mode_q;
        sent_d       = sent_q;
        pop          = 1'b0;
        go_clear     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    go_clear = 1'b1;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    voter_d = 4'b0001 << mem_q[rd_q];
                    state_d = S_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                end else if (close_pend_q) begin
                    state_d = S_CLOSED;
                    mode_d  = 2'b01;
                end
            end
            S_SETUP: begin
                if (clear_req) begin
                    go_clear = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = S_PULSE;
                    confirm_d = 1'b1;
                    cnt_d     = CW'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PULSE: begin
                if (clear_req) begin
                    go_clear = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = S_HOLD;
                    confirm_d = 1'b0;
                    cnt_d     = CW'(HOLD_CYC - 1);
                    if (sent_q != 8'hFF) sent_d = sent_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (clear_req) begin
                    go_clear = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    voter_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    mode_d  = 2'b00;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CLOSED: begin
                if (clear_req) go_clear = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Aborting clear: outputs drop immediately, queue/count wiped, ballot in flight not counted.
        if (go_clear) begin
            state_d      = S_CLEAR;
            cnt_d        = CW'(CLEAR_CYC - 1);
            mode_d       = 2'b10;
            voter_d      = '0;
            confirm_d    = 1'b0;
            sent_d       = '0;
            close_pend_d = 1'b0;
            wr_d         = '0;
            rd_d         = '0;
            count_d      = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = vote_cand;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            count_d = count_q + NW'(push) - NW'(pop);
        end

        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            close_pend_q <= 1'b0;
            voter_q      <= '0;
            confirm_q    <= 1'b0;
            mode_q       <= 2'b00;
            busy_q       <= 1'b0;
            sent_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            close_pend_q <= close_pend_d;
            voter_q      <= voter_d;
            confirm_q    <= confirm_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            sent_q       <= sent_d;
        end
    end

endmodule
